// File: rtl/pcle_counter.sv
// Up/down load/enable counter with reload register, terminal-count and wrap pulse.
// Optional feature: define PCLE_COUNTER_SAT_EN to saturate at terminal count (adds sat_o).
module pcle_counter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned RST_VAL     = 0,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic             inhibit_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
`ifdef PCLE_COUNTER_SAT_EN
  output logic             sat_o,
`endif
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] RST_VAL_W = RST_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             wrap_q, wrap_d;
  logic             active;
  logic [WIDTH-1:0] term_val;

  assign active   = en_i & ~inhibit_i & ~load_i;
  assign term_val = dir_i ? ALL_ONES : ZERO;
  assign tc_o     = active & (count_q == term_val);

`ifdef PCLE_COUNTER_SAT_EN
  logic sat_q, sat_d;
`endif

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    wrap_d   = 1'b0;
`ifdef PCLE_COUNTER_SAT_EN
    sat_d    = sat_q;
`endif
    if (load_i) begin
      count_d  = load_val_i;
      reload_d = load_val_i;
`ifdef PCLE_COUNTER_SAT_EN
      sat_d    = 1'b0;
`endif
    end else if (active & ~tc_o) begin
      count_d = dir_i ? (count_q + ONE) : (count_q - ONE);
    end else if (active & tc_o) begin
`ifdef PCLE_COUNTER_SAT_EN
      // Saturating: count stays at the terminal value, only the sticky flag moves.
      sat_d = 1'b1;
`else
      if (AUTO_RELOAD) begin
        count_d = reload_q;
      end else begin
        count_d = dir_i ? ZERO : ALL_ONES;
      end
      wrap_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= RST_VAL_W;
      reload_q <= RST_VAL_W;
      wrap_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      wrap_q   <= wrap_d;
    end
  end

`ifdef PCLE_COUNTER_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_o = sat_q;
`endif

  assign count_o = count_q;
  assign wrap_o  = wrap_q;

endmodule

// File: doc/pcle_counter.md
Name: pcle_counter

Overview:
- Parametrised, registered successor to the 8-bit load/count-enable/carry next-state logic in the MCNC-style counter blocks.
- Holds count state internally and adds: up/down direction, hold when idle, a reload register with auto-reload on terminal count, and a registered wrap pulse.
- Sits as a leaf timer/counter and is cascadable: stage N+1 en_i is driven from stage N tc_o.

Parameters:
- WIDTH, 8: counter width in bits; legal range 2..32.
- RST_VAL, 0: value of count_o and of the reload register after reset; truncated to WIDTH.
- AUTO_RELOAD, 0: 1 = on terminal count, reload from the reload register instead of wrapping.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_i  in  1  synchronous load strobe.
- load_val_i  in  WIDTH  value for count_o and the reload register when load_i=1.
- en_i  in  1  count enable.
- inhibit_i  in  1  count inhibit; overrides en_i.
- dir_i  in  1  1 = count up, 0 = count down.
- count_o  out  WIDTH  current count, registered.
- tc_o  out  1  terminal count, combinational.
- wrap_o  out  1  one-cycle pulse, registered.

Behaviour:
- Reset (rst_n=0, asynchronous): count_o=RST_VAL, reload_q=RST_VAL, wrap_o=0. tc_o follows its equation, so it is 0 because active=0 only if en_i/inhibit_i/load_i make it so.
- active = en_i & ~inhibit_i & ~load_i.
- Terminal value: all-ones when dir_i=1; zero when dir_i=0.
- tc_o = active & (count_o == terminal value). Combinational; no register stage.
- Per rising clk, highest priority first:
  1. load_i=1: count_o<=load_val_i; reload_q<=load_val_i; wrap_o<=0. en_i, inhibit_i and dir_i are ignored.
  2. active & ~tc_o: count_o<=count_o+1 (dir_i=1) or count_o-1 (dir_i=0), modulo 2^WIDTH; wrap_o<=0.
  3. active & tc_o, wrap case:
     - AUTO_RELOAD=0: count_o<=0 (up) or all-ones (down).
     - AUTO_RELOAD=1: count_o<=reload_q, in either direction.
     - In both cases wrap_o<=1.
  4. Otherwise: count_o holds; wrap_o<=0.
- Latency:
  - count_o changes one cycle after the qualifying edge.
  - wrap_o is high for exactly the cycle after the wrap edge, aligned with the wrapped count_o value.
- dir_i may change on any cycle; it takes effect at the next edge with no extra latency.
- Cascade: stage N+1 en_i = stage N tc_o. The chain then counts as one WIDTH*k counter, provided all stages share dir_i and inhibit_i.
- load_i and inhibit_i both high: load wins.
- rst_n asserted mid-count: state returns to reset values immediately. Counting resumes on the first edge after release with active=1.
- Arithmetic is unsigned. No output is X after reset, and none exceeds WIDTH bits.

Optional Feature:
- Macro: PCLE_COUNTER_SAT_EN.
- Defined: the wrap case (priority 3) is replaced by saturation.
  - count_o holds at the terminal value; wrap_o stays 0; AUTO_RELOAD is ignored.
  - A sticky output sat_o (1 bit, registered) sets on the first saturating edge.
  - sat_o clears on load_i or reset.
  - tc_o behaves as in the base mode.
- Not defined: sat_o port is absent; wrap/reload behaviour as above.

Test Plan:
- Reset/load: WIDTH=8, RST_VAL=0x05. Release rst_n -> count_o=0x05, wrap_o=0. Then load_i=1 with load_val_i=0xA3, simultaneously en_i=1 -> next count_o=0xA3 (load wins, no increment).
- Up-wrap: load 0xFD, then en_i=1, dir_i=1 for 4 cycles -> count_o 0xFE, 0xFF, 0x00, 0x01.
  - tc_o high during the 0xFF cycle only.
  - wrap_o high only in the 0x00 cycle.
- Down with inhibit: load 0x02, dir_i=0, en_i=1; inhibit_i=1 on the second cycle -> count_o 0x01, 0x01 (hold), 0x00, 0xFF.
  - tc_o high during the 0x00 cycle.
  - tc_o stays 0 while inhibit_i=1.
- Auto-reload: AUTO_RELOAD=1, load 0xFE, count up 3 cycles -> 0xFF, 0xFE (reload), 0xFF; wrap_o pulses with the 0xFE reload.
- Cascade and async reset:
  - Two WIDTH=4 stages, low stage tc_o drives high stage en_i. Start at 0x0E, count 3 cycles -> 0x0F, 0x10, 0x11.
  - Drop rst_n mid-cycle -> both outputs return to RST_VAL before the next edge.
- PCLE_COUNTER_SAT_EN defined: load 0xFE, count up 3 cycles -> 0xFF, 0xFF, 0xFF.
  - sat_o=1 from the second 0xFF onward; wrap_o never asserts.
  - load 0x10 -> sat_o=0.
